// File: rtl/pixel_writer.sv
// Shader pixel sink: clips, linearises and packs pixels to RGB565, buffers them in a FIFO
// and drains them over a valid/ready memory port. Optional counters: PIXEL_WRITER_STATS_EN.
module pixel_writer #(
   parameter int H_RES  = 640,
   parameter int V_RES  = 480,
   parameter int ADDR_W = 19,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              write_pixel,
   input  logic [15:0]       x_pixel,
   input  logic [15:0]       y_pixel,
   input  logic [7:0]        R,
   input  logic [7:0]        G,
   input  logic [7:0]        B,
   input  logic              done,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_data,
   input  logic              mem_ack,
   output logic              busy,
   output logic              frame_done,
   output logic              overflow
`ifdef PIXEL_WRITER_STATS_EN
   ,
   output logic [31:0]       pix_count,
   output logic [31:0]       drop_count
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = ADDR_W + 16;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t state, state_next;

   logic              in_range;
   logic              clip;
   logic [ADDR_W-1:0] lin_addr;
   logic              unused_colour;

   logic              s1_valid;
   logic [ADDR_W-1:0] s1_addr;
   logic [15:0]       s1_data;

   logic [ENT_W-1:0]  fifo_mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  count, count_next;
   logic              full, pop, push, drop;
   logic [ENT_W-1:0]  head;

   assign in_range      = ({16'd0, x_pixel} < 32'(H_RES)) && ({16'd0, y_pixel} < 32'(V_RES));
   assign clip          = write_pixel && !in_range;
   assign lin_addr      = ADDR_W'(32'(y_pixel) * 32'(H_RES) + 32'(x_pixel));
   assign unused_colour = ^{R[2:0], G[1:0], B[2:0]};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid <= 1'b0;
         s1_addr  <= '0;
         s1_data  <= '0;
      end else begin
         s1_valid <= write_pixel && in_range;
         s1_addr  <= lin_addr;
         s1_data  <= {R[7:3], G[7:2], B[7:3]};
      end
   end

   // A full FIFO still accepts a push when its head leaves in the same cycle.
   always_comb begin
      full       = (count == CNT_W'(DEPTH));
      pop        = mem_req && mem_ack;
      push       = s1_valid && (!full || pop);
      drop       = s1_valid && full && !pop;
      count_next = count;
      if (push && !pop)
         count_next = count + CNT_W'(1);
      else if (!push && pop)
         count_next = count - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= {s1_addr, s1_data};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)
            rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count_next;
      end
   end

   assign head     = fifo_mem[rd_ptr];
   assign mem_req  = (count != '0);
   assign mem_addr = mem_req ? head[ENT_W-1:16] : '0;
   assign mem_data = mem_req ? head[15:0] : '0;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Completion looks at the post-transfer FIFO level so frame_done follows the last write directly.
   always_comb begin
      state_next = state;
      if (start) begin
         state_next = RUN;
      end else begin
         case (state)
            RUN:     if (done) state_next = DRAIN;
            DRAIN:   if (!s1_valid && count_next == '0) state_next = DONE;
            default: state_next = state;
         endcase
      end
   end

   assign busy       = (state == RUN) || (state == DRAIN);
   assign frame_done = (state == DONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         overflow <= 1'b0;
      else if (start)
         overflow <= 1'b0;
      else if (drop)
         overflow <= 1'b1;
   end

`ifdef PIXEL_WRITER_STATS_EN
   logic [1:0]  drop_inc;
   logic [32:0] drop_sum;

   assign drop_inc = {1'b0, clip} + {1'b0, drop};
   assign drop_sum = {1'b0, drop_count} + {31'd0, drop_inc};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pix_count  <= '0;
         drop_count <= '0;
      end else if (start) begin
         pix_count  <= '0;
         drop_count <= '0;
      end else begin
         if (pop && pix_count != 32'hFFFF_FFFF)
            pix_count <= pix_count + 32'd1;
         drop_count <= drop_sum[32] ? 32'hFFFF_FFFF : drop_sum[31:0];
      end
   end
`else
   logic unused_clip;
   assign unused_clip = clip;
`endif

endmodule

// File: tb/tb_pixel_writer.sv
// Self-checking bench for pixel_writer: queue-based reference model plus a negedge monitor
// that compares every presented memory word and the status outputs.
module tb_pixel_writer;

   localparam int H_RES  = 640;
   localparam int V_RES  = 480;
   localparam int ADDR_W = 19;
   localparam int DEPTH  = 16;
   localparam int W      = ADDR_W + 16;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              write_pixel = 1'b0;
   logic [15:0]       x_pixel = '0;
   logic [15:0]       y_pixel = '0;
   logic [7:0]        R = '0, G = '0, B = '0;
   logic              done = 1'b0;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       mem_data;
   logic              mem_ack = 1'b0;
   logic              busy, frame_done, overflow;
`ifdef PIXEL_WRITER_STATS_EN
   logic [31:0]       pix_count, drop_count;
`endif

   pixel_writer #(.H_RES(H_RES), .V_RES(V_RES), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .start(start), .write_pixel(write_pixel),
      .x_pixel(x_pixel), .y_pixel(y_pixel), .R(R), .G(G), .B(B), .done(done),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
      .busy(busy), .frame_done(frame_done), .overflow(overflow)
`ifdef PIXEL_WRITER_STATS_EN
      , .pix_count(pix_count), .drop_count(drop_count)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int n_xfer   = 0;
   logic [ADDR_W-1:0] last_addr = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: words expected in memory order, frame phase, sticky overflow.
   logic [W-1:0] exp_q[$];
   int           phase = 0;  // 0 idle, 1 running, 2 draining, 3 frame complete
   bit           m_ovf = 1'b0;
   bit           s1_v  = 1'b0;
   logic [W-1:0] s1_e  = '0;

   function automatic logic [W-1:0] pix_word(input int x, input int y, input int r, input int g, input int b);
      int a, d;
      a = (y * H_RES + x) % (1 << ADDR_W);
      d = ((r >> 3) << 11) | ((g >> 2) << 5) | (b >> 3);
      return {a[ADDR_W-1:0], d[15:0]};
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         exp_q.delete();
         phase = 0;
         m_ovf = 1'b0;
         s1_v  = 1'b0;
      end else begin
         int ph_n;
         ph_n = phase;
         if (start) ph_n = 1;
         else if (phase == 1 && done) ph_n = 2;
         else if (phase == 2 && !s1_v && exp_q.size() == 0) ph_n = 3;
         if (s1_v) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(s1_e);
            else m_ovf = 1'b1;
         end
         if (start) m_ovf = 1'b0;
         phase = ph_n;
         s1_v  = write_pixel && (int'(x_pixel) < H_RES) && (int'(y_pixel) < V_RES);
         s1_e  = pix_word(int'(x_pixel), int'(y_pixel), int'(R), int'(G), int'(B));
      end
   end

   // Monitor: compare presented word and status, pop on each transfer.
   always @(negedge clk) begin
      if (!reset) begin
         check("mem_req", 64'(mem_req), 64'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            check("mem_addr", 64'(mem_addr), 64'(exp_q[0][W-1:16]));
            check("mem_data", 64'(mem_data), 64'(exp_q[0][15:0]));
         end
         check("busy", 64'(busy), 64'(phase == 1 || phase == 2));
         check("frame_done", 64'(frame_done), 64'(phase == 3));
         check("overflow", 64'(overflow), 64'(m_ovf));
         if (mem_req && mem_ack) begin
            n_xfer++;
            last_addr = mem_addr;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
      end
   end

   // mem_ack: 0 low, 1 high, 2 alternating, 3 random
   int ack_mode = 0;
   always @(posedge clk) begin
      #1;
      case (ack_mode)
         0:       mem_ack = 1'b0;
         1:       mem_ack = 1'b1;
         2:       mem_ack = ~mem_ack;
         default: mem_ack = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic step(input bit wp, input int x, input int y, input int r, input int g, input int b,
                       input bit st, input bit dn);
      @(posedge clk);
      #1;
      write_pixel = wp;
      x_pixel = 16'(x);
      y_pixel = 16'(y);
      R = 8'(r);
      G = 8'(g);
      B = 8'(b);
      start = st;
      done = dn;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
   endtask

   task automatic wait_frame_done(input int budget);
      int k;
      k = 0;
      while (!frame_done && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("frame_done_within_budget", 64'(frame_done), 64'd1);
   endtask

   initial begin
      int x0;
      // Reset state
      #1;
      check("rst_mem_req", 64'(mem_req), 64'd0);
      check("rst_mem_addr", 64'(mem_addr), 64'd0);
      check("rst_mem_data", 64'(mem_data), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_frame_done", 64'(frame_done), 64'd0);
      check("rst_overflow", 64'(overflow), 64'd0);
      #20;
      @(negedge clk);
      #2 reset = 1'b0;
      idle(2);

      // Single pixel, two-cycle latency
      ack_mode = 1;
      idle(1);
      step(1'b1, 3, 2, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0);
      step(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      @(negedge clk);
      check("single_n1_req", 64'(mem_req), 64'd0);
      @(negedge clk);
      check("single_n2_req", 64'(mem_req), 64'd1);
      check("single_addr", 64'(mem_addr), 64'd1283);
      check("single_data", 64'(mem_data), 64'hF81F);
      @(negedge clk);
      check("single_n3_req", 64'(mem_req), 64'd0);

      // Clipping
      x0 = n_xfer;
      step(1'b1, 640, 0, 1, 2, 3, 1'b0, 1'b0);
      step(1'b1, 0, 480, 4, 5, 6, 1'b0, 1'b0);
      step(1'b1, 639, 479, 8'h12, 8'h34, 8'h56, 1'b0, 1'b0);
      idle(5);
      check("clip_transfers", 64'(n_xfer - x0), 64'd1);
      check("clip_addr", 64'(last_addr), 64'd307199);
      check("clip_overflow", 64'(overflow), 64'd0);

      // Backpressure and overflow
      ack_mode = 0;
      idle(2);
      for (int i = 0; i < 20; i++) step(1'b1, i, 0, i * 7, i * 13, i * 29, 1'b0, 1'b0);
      idle(3);
      check("bp_overflow", 64'(overflow), 64'd1);
      x0 = n_xfer;
      ack_mode = 1;
      idle(25);
      check("bp_transfers", 64'(n_xfer - x0), 64'd16);
      check("bp_last_addr", 64'(last_addr), 64'd15);

      // Full FIFO with simultaneous pop
      step(1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
      ack_mode = 0;
      for (int i = 0; i < 16; i++) step(1'b1, 100 + i, 1, i, i, i, 1'b0, 1'b0);
      idle(3);
      check("full_no_ovf_yet", 64'(overflow), 64'd0);
      x0 = n_xfer;
      ack_mode = 1;
      for (int i = 0; i < 10; i++) step(1'b1, 200 + i, 1, 255 - i, i, 3 * i, 1'b0, 1'b0);
      idle(30);
      check("fullpop_overflow", 64'(overflow), 64'd0);
      check("fullpop_transfers", 64'(n_xfer - x0), 64'd26);

      // Frame completion with alternating ack
      ack_mode = 2;
      step(1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
      x0 = n_xfer;
      for (int i = 0; i < 5; i++) step(1'b1, 10 * i, 3, 8'hA0, 8'h50, 8'h28, 1'b0, 1'b0);
      step(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      step(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      wait_frame_done(100);
      check("frame_transfers", 64'(n_xfer - x0), 64'd5);
      check("frame_busy_low", 64'(busy), 64'd0);
      step(1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
      step(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      @(negedge clk);
      check("restart_clears_done", 64'(frame_done), 64'd0);

      // Randomized frame
      ack_mode = 3;
      for (int i = 0; i < 300; i++)
         step(($urandom_range(0, 9) < 7), $urandom_range(0, 700), $urandom_range(0, 520),
              $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255), 1'b0, 1'b0);
      step(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      step(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      wait_frame_done(300);

      // Async reset while draining
      ack_mode = 0;
      step(1'b0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, i, 9, i, i, i, 1'b0, 1'b0);
      step(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b1);
      step(1'b0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
      @(negedge clk);
      check("pre_reset_req", 64'(mem_req), 64'd1);
      #2 reset = 1'b1;
      #1;
      check("arst_mem_req", 64'(mem_req), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_frame_done", 64'(frame_done), 64'd0);
      check("arst_overflow", 64'(overflow), 64'd0);
      @(negedge clk);
      #2 reset = 1'b0;
      x0 = n_xfer;
      ack_mode = 1;
      idle(10);
      check("no_stale_transfer", 64'(n_xfer - x0), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pixel_writer.md
Name: pixel_writer

Overview:
- Sink end of the shader pixel stream: consumes write_pixel/x_pixel/y_pixel/R/G/B strobes and writes them into a framebuffer memory.
- Clips off-screen pixels and computes the linear address y*H_RES+x.
- Packs colour to RGB565 and buffers pixels in a FIFO, because the shader has no backpressure.
- Drains the FIFO over a valid/ready memory handshake and reports frame completion after shader done.

Parameters:
- H_RES, 640, visible width in pixels.
- V_RES, 480, visible height in pixels.
- ADDR_W, 19, framebuffer word-address width; must hold H_RES*V_RES-1.
- DEPTH, 16, FIFO entries; power of two, >=2.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  same pulse that starts the shader; clears sticky flags and frame_done.
- write_pixel  in  1  pixel strobe from shader, one pixel per cycle when high.
- x_pixel  in  16  unsigned integer column.
- y_pixel  in  16  unsigned integer row.
- R, G, B  in  8 each  pixel colour.
- done  in  1  shader done; level or pulse, edge-insensitive.
- mem_req  out  1  memory write valid.
- mem_addr  out  ADDR_W  word address.
- mem_data  out  16  RGB565 {R[7:3],G[7:2],B[7:3]}.
- mem_ack  in  1  memory ready; a transfer occurs on any cycle where mem_req && mem_ack.
- busy  out  1  high in RUN or DRAIN.
- frame_done  out  1  level; all pixels of the triangle are written.
- overflow  out  1  sticky; at least one pixel was lost to a full FIFO.

Behaviour:
- Reset (async): FIFO flushed, pipeline register invalid, state IDLE. All outputs 0: mem_req, mem_addr, mem_data, busy, frame_done, overflow.
- Reset mid-operation: mem_req drops immediately; any pending pixels are discarded.
- Stage 1 (registered, cycle N+1 after a strobe at N):
  - Clip test: accepted only if x_pixel<H_RES and y_pixel<V_RES.
  - Compute addr=y*H_RES+x truncated to ADDR_W, and the RGB565 word.
  - Clipped pixels vanish: no FIFO push, no overflow.
- Stage 2: valid stage-1 entry pushed into the FIFO. Earliest mem_req for a pixel strobed at cycle N is N+2 (FIFO empty, first-word-fall-through output).
- Memory side:
  - mem_req=!fifo_empty; mem_addr/mem_data = FIFO head, held stable while mem_req && !mem_ack.
  - On a transfer the head pops. The next entry is presented the following cycle without a gap.
- Full FIFO with push and no pop: pixel dropped, overflow<=1.
- Full FIFO with push and pop in the same cycle: both occur, no drop.
- Empty FIFO with push: count goes 0->1 and mem_req rises next cycle.
- Count width is log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- State machine (state transitions are synchronous; only reset acts asynchronously):
  - IDLE: start -> RUN, clearing overflow and frame_done. Pixels arriving in IDLE are still written (no gating).
  - RUN: done seen -> DRAIN.
  - DRAIN: stage 1 invalid && FIFO empty -> DONE.
  - DONE: frame_done=1, busy=0. start -> RUN, clearing frame_done and overflow.
- start in RUN or DRAIN: restarts to RUN, clears flags, does not flush the FIFO.
- start and done in the same cycle: start wins.
- done in IDLE: ignored.

Optional Feature:
- Macro: PIXEL_WRITER_STATS_EN.
- Defined: adds outputs pix_count[31:0] (incremented per memory transfer) and drop_count[31:0] (incremented per clipped or overflowed pixel, +1 per pixel).
  - Both zeroed by reset and by start.
  - Both saturate at 0xFFFFFFFF.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Single pixel, mem_ack tied 1: strobe x=3,y=2,R=FF,G=00,B=FF at N -> mem_req at N+2 for exactly 1 cycle, mem_addr=1283, mem_data=F81F.
- Clipping: strobes (640,0), (0,480), (639,479) -> only one transfer, addr=307199; overflow stays 0.
- Backpressure: mem_ack=0, DEPTH=16, 20 consecutive strobes x=0..19, y=0 -> overflow=1; then release ack -> exactly 16 transfers, addresses 0..15 in order, each held stable while unacked.
- Full-with-pop: FIFO at 16 with mem_ack=1 and continuous strobes -> no drop and overflow stays 0.
- Frame completion: start, 5 strobes, done pulse, mem_ack alternating 1/0 -> frame_done rises the cycle after the 5th transfer; busy falls with it; next start clears it.
- Async reset mid-drain: reset asserted between clock edges with mem_req=1 -> mem_req, busy, frame_done, overflow all 0 immediately; after release, no stale transfer occurs.
